// File: rtl/sha_pool_core.sv
// sha_pool_core: N_UNITS parallel SHA-256 compression units sharing one round
// controller and one K-constant ROM. Every unit compresses the same block and
// chaining value; only message word NONCE_WORD differs (nonce_base + unit index).
module sha_pool_core #(
    parameter int N_UNITS    = 4,
    parameter int NONCE_WORD = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [511:0]           M,
    input  logic [255:0]           H0,
    input  logic [31:0]            nonce_base,
    output logic                   busy,
    output logic                   done,
    output logic [N_UNITS*256-1:0] H1
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t       state_q, state_d;
    logic [5:0]   round_q, round_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [255:0] h0_q, h0_d;
    logic [31:0]  k_q;
    logic         load;

    // Round controller: accepts a job only in IDLE, runs 64 rounds, then one FINISH cycle.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        h0_d    = h0_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    h0_d    = H0;
                    round_d = 6'd0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // 6-bit counter wraps to 0 on the round-63 cycle
                round_d = round_q + 6'd1;
                if (round_q == 6'd63) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers; reset discards any job in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            round_q <= 6'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            h0_q    <= '0;
        end else begin
            state_q <= state_d;
            round_q <= state_d == IDLE ? 6'd0 : round_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            h0_q    <= h0_d;
        end
    end

    // K ROM with registered read: addressed by the next round so k_q matches round_q.
    always_ff @(posedge clk) begin
        k_q <= K_ROM[round_d];
    end

    assign busy = busy_q;
    assign done = done_q;

    for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_unit
        logic [31:0]  w_q [16];
        logic [31:0]  w_d [16];
        logic [255:0] wv_q, wv_d;
        logic [255:0] h1_q, h1_d;
        logic [31:0]  a_w, b_w, c_w, d_w, e_w, f_w, g_w, h_w;
        logic [31:0]  t1, t2, w_new;

        assign {a_w, b_w, c_w, d_w, e_w, f_w, g_w, h_w} = wv_q;
        assign t1    = h_w + big_sigma1(e_w) + ((e_w & f_w) ^ (~e_w & g_w)) + k_q + w_q[0];
        assign t2    = big_sigma0(a_w) + ((a_w & b_w) ^ (a_w & c_w) ^ (b_w & c_w));
        assign w_new = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];

        // Per-unit datapath: load window and working vars, run a round, or fold into H1.
        always_comb begin
            w_d  = w_q;
            wv_d = wv_q;
            h1_d = h1_q;
            if (load) begin
                for (int j = 0; j < 16; j++) begin
                    w_d[j] = M[511 - 32*j -: 32];
                end
                w_d[NONCE_WORD] = nonce_base + 32'(gi);
                wv_d = H0;
            end else if (state_q == RUN) begin
                // w_q[0] is always Wt; the window slides one word per round
                for (int j = 0; j < 15; j++) begin
                    w_d[j] = w_q[j + 1];
                end
                w_d[15] = w_new;
                wv_d = {t1 + t2, a_w, b_w, c_w, d_w + t1, e_w, f_w, g_w};
            end else if (state_q == FINISH) begin
                for (int j = 0; j < 8; j++) begin
                    h1_d[255 - 32*j -: 32] = h0_q[255 - 32*j -: 32] + wv_q[255 - 32*j -: 32];
                end
            end
        end

        // Result register is reset; window and working vars are always reloaded at start.
        always_ff @(posedge clk) begin
            if (reset) begin
                h1_q <= '0;
            end else begin
                h1_q <= h1_d;
            end
        end

        // Working state registers.
        always_ff @(posedge clk) begin
            w_q  <= w_d;
            wv_q <= wv_d;
        end

        assign H1[256*gi +: 256] = h1_q;
    end

endmodule

// File: tb/tb_sha_pool_core.sv
// Bench for sha_pool_core: a 1-unit instance runs FIPS vectors, reset and
// back-to-back tests; a 4-unit instance checks nonce wrap and start filtering.
// Expected results are queued at issue and checked by per-instance monitors.
module tb_sha_pool_core;

    localparam logic [255:0] IV  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] B1  = 256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
    localparam logic [255:0] B2  = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    localparam logic [511:0] M_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] M_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] M_B2  = {480'h0, 32'h000001c0};

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        logic [1023:0] h1;
        int            cyc;
        int            id;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset_a, reset_b, start_a, start_b;
    logic [511:0]   m_a, m_b;
    logic [255:0]   h0_a, h0_b;
    logic [31:0]    nb_a, nb_b;
    logic           busy_a, busy_b, done_a, done_b;
    logic [255:0]   h1_a;
    logic [1023:0]  h1_b;

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    sha_pool_core #(.N_UNITS(1), .NONCE_WORD(0)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .M(m_a), .H0(h0_a),
        .nonce_base(nb_a), .busy(busy_a), .done(done_a), .H1(h1_a)
    );

    sha_pool_core #(.N_UNITS(4), .NONCE_WORD(3)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .M(m_b), .H0(h0_b),
        .nonce_base(nb_b), .busy(busy_b), .done(done_b), .H1(h1_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Plain software SHA-256 compression with a full 64-entry schedule.
    function automatic logic [255:0] sha_model(input logic [511:0] m, input logic [255:0] h0);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2, s0, s1;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = m[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = h0[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TAB[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = h0[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor for the 1-unit instance.
    always @(negedge clk) begin
        exp_t e;
        if (done_a === 1'b1) begin
            if (q_a.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL done_a_unexpected: got done=1 at cycle %0d, required no done", cyc);
            end else begin
                e = q_a.pop_front();
                check("h1_a", {768'b0, h1_a}, e.h1);
                check("latency_a", 1024'(cyc), 1024'(e.cyc));
                $display("A job %0d: done at cycle %0d (due %0d) H1=%h", e.id, cyc, e.cyc, h1_a);
            end
        end
    end

    // Monitor for the 4-unit instance.
    always @(negedge clk) begin
        exp_t e;
        if (done_b === 1'b1) begin
            if (q_b.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL done_b_unexpected: got done=1 at cycle %0d, required no done", cyc);
            end else begin
                e = q_b.pop_front();
                check("h1_b", h1_b, e.h1);
                check("latency_b", 1024'(cyc), 1024'(e.cyc));
                $display("B job %0d: done at cycle %0d (due %0d)", e.id, cyc, e.cyc);
            end
        end
    end

    task automatic wait_drain(input int which);
        int i = 0;
        int left;
        left = (which == 0) ? q_a.size() : q_b.size();
        while (left != 0 && i < 300) begin
            @(posedge clk);
            i++;
            left = (which == 0) ? q_a.size() : q_b.size();
        end
        n_cmp++;
        if (left != 0) begin
            n_err++;
            $display("FAIL drain_%0d: %0d results outstanding after %0d cycles, required 0", which, left, i);
            if (which == 0) q_a.delete(); else q_b.delete();
        end
    endtask

    task automatic run_a(input logic [511:0] m, input logic [255:0] h0, input logic [31:0] nb,
                         input logic [255:0] req, input int id);
        exp_t e;
        @(posedge clk); #1;
        m_a = m; h0_a = h0; nb_a = nb; start_a = 1'b1;
        e.h1 = {768'b0, req}; e.cyc = cyc + 66; e.id = id;
        q_a.push_back(e);
        $display("A job %0d: issued at cycle %0d", id, cyc);
        @(posedge clk); #1;
        start_a = 1'b0; m_a = ~m; h0_a = ~h0; nb_a = ~nb;
        wait_drain(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t          e;
        int            c0;
        logic [1023:0] exp_b;
        logic [511:0]  mu;

        reset_a = 1'b1; reset_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        m_a = '0; m_b = '0; h0_a = '0; h0_b = '0; nb_a = '0; nb_b = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_a = 1'b0; reset_b = 1'b0;
        check("reset_busy_a", 1024'(busy_a), 1024'(0));
        check("reset_done_a", 1024'(done_a), 1024'(0));
        check("reset_h1_a", {768'b0, h1_a}, 1024'(0));
        check("reset_busy_b", 1024'(busy_b), 1024'(0));
        check("reset_done_b", 1024'(done_b), 1024'(0));
        check("reset_h1_b", h1_b, 1024'(0));

        // FIPS single block and two-block chaining
        run_a(M_ABC, IV, 32'h61626380, ABC, 1);
        run_a(M_B1, IV, 32'h61626364, B1, 2);
        run_a(M_B2, B1, 32'h00000000, B2, 3);

        // Reset in the middle of a job: nothing queued, so any done is flagged
        @(posedge clk); #1;
        m_a = M_ABC; h0_a = IV; nb_a = 32'h61626380; start_a = 1'b1;
        $display("A job 4: issued at cycle %0d, reset planned at round 30", cyc);
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("busy_round30_a", 1024'(busy_a), 1024'(1));
        reset_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_busy_a", 1024'(busy_a), 1024'(0));
        check("midreset_done_a", 1024'(done_a), 1024'(0));
        check("midreset_h1_a", {768'b0, h1_a}, 1024'(0));
        reset_a = 1'b0;
        repeat (80) @(posedge clk);
        run_a(M_ABC, IV, 32'h61626380, ABC, 5);

        // start held high: jobs every 66 cycles, inputs swapped after each start edge
        @(posedge clk); #1;
        c0 = cyc;
        m_a = M_ABC; h0_a = IV; nb_a = 32'h61626380; start_a = 1'b1;
        e.h1 = {768'b0, ABC}; e.cyc = c0 + 66; e.id = 6; q_a.push_back(e);
        $display("A job 6: start held from cycle %0d", c0);
        @(posedge clk); #1;
        m_a = M_B1; h0_a = IV; nb_a = 32'h61626364;
        e.h1 = {768'b0, B1}; e.cyc = c0 + 132; e.id = 7; q_a.push_back(e);
        repeat (66) @(posedge clk);
        #1;
        m_a = M_B2; h0_a = B1; nb_a = 32'h00000000;
        e.h1 = {768'b0, B2}; e.cyc = c0 + 198; e.id = 8; q_a.push_back(e);
        repeat (66) @(posedge clk);
        #1;
        start_a = 1'b0; m_a = '1; h0_a = '0; nb_a = 32'hdeadbeef;
        wait_drain(0);
        repeat (70) @(posedge clk);

        // Four units, nonce wrapping past FFFFFFFF
        for (int i = 0; i < 4; i++) begin
            mu = M_B1;
            mu[511 - 32*3 -: 32] = 32'hfffffffe + 32'(i);
            exp_b[256*i +: 256] = sha_model(mu, IV);
        end
        @(posedge clk); #1;
        m_b = M_B1; h0_b = IV; nb_b = 32'hfffffffe; start_b = 1'b1;
        e.h1 = exp_b; e.cyc = cyc + 66; e.id = 1; q_b.push_back(e);
        $display("B job 1: issued at cycle %0d, nonce_base fffffffe", cyc);
        @(posedge clk); #1;
        start_b = 1'b0; m_b = '0; h0_b = '1; nb_b = 32'h12345678;
        wait_drain(1);

        // Same job with start pulses at round 10 and round 63 carrying other inputs
        @(posedge clk); #1;
        m_b = M_B1; h0_b = IV; nb_b = 32'hfffffffe; start_b = 1'b1;
        e.h1 = exp_b; e.cyc = cyc + 66; e.id = 2; q_b.push_back(e);
        $display("B job 2: issued at cycle %0d, start pulses at rounds 10 and 63", cyc);
        @(posedge clk); #1;
        start_b = 1'b0; m_b = M_ABC; h0_b = B2; nb_b = 32'h00000055;
        repeat (10) @(posedge clk);
        #1;
        check("busy_round10_b", 1024'(busy_b), 1024'(1));
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        repeat (52) @(posedge clk);
        #1;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        wait_drain(1);
        repeat (80) @(posedge clk);
        check("idle_busy_b", 1024'(busy_b), 1024'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
